// File: rtl/int_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : int_mul_iter
// Description : Iterative signed/unsigned integer multiplier, BITS_PER_CYCLE
//               multiplier bits retired per cycle, four-phase req/ack.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module int_mul_iter #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             high,
    output logic [WIDTH-1:0] out,
    output logic             ack,
    output logic             busy
);

    localparam int c_SW = $clog2(WIDTH + 1);
    localparam int c_PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_FINISH = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [c_PW-1:0]  r_acc;
    logic [c_SW-1:0]  r_shift;
    logic             r_neg;
    logic             r_high;
    logic [WIDTH-1:0] r_out;
    logic             r_ack;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_neg;
    logic [c_PW-1:0]  w_mcand_ext;
    logic [c_PW-1:0]  w_digit_ext;
    logic [c_PW-1:0]  w_pp;
    logic [WIDTH-1:0] w_mplier_next;
    logic [c_SW-1:0]  w_shift_next;
    logic             w_mult_done;
    logic [c_PW-1:0]  w_product;

    // Signed operands are reduced to magnitudes; the most negative value
    // maps onto 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    assign w_a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign w_neg   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

    assign w_mcand_ext   = {{WIDTH{1'b0}}, r_mcand};
    assign w_digit_ext   = {{(c_PW - BITS_PER_CYCLE){1'b0}}, r_mplier[BITS_PER_CYCLE-1:0]};
    assign w_pp          = (w_mcand_ext * w_digit_ext) << r_shift;
    assign w_mplier_next = r_mplier >> BITS_PER_CYCLE;
    assign w_shift_next  = r_shift + c_SW'(BITS_PER_CYCLE);
    assign w_mult_done   = (w_mplier_next == '0) || (w_shift_next >= c_SW'(WIDTH));
    assign w_product     = r_neg ? (~r_acc + 1'b1) : r_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_next = S_MULT;
                end
            end
            S_MULT: begin
                if (w_mult_done) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!req) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_shift  <= '0;
            r_neg    <= 1'b0;
            r_high   <= 1'b0;
            r_out    <= '0;
            r_ack    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_neg    <= w_neg;
                        r_high   <= high;
                        r_acc    <= '0;
                        r_shift  <= '0;
                    end
                end
                S_MULT: begin
                    r_acc    <= r_acc + w_pp;
                    r_mplier <= w_mplier_next;
                    r_shift  <= w_shift_next;
                end
                S_FINISH: begin
                    r_out <= r_high ? w_product[c_PW-1:WIDTH] : w_product[WIDTH-1:0];
                    r_ack <= 1'b1;
                end
                S_WAIT: begin
                    if (!req) begin
                        r_ack <= 1'b0;
                    end
                end
                default: begin
                    r_ack <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign ack  = r_ack;
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire
